sm4_word_packer: RTL and testbench

Upstream front end of `sm4_encryptor`. Accepts a narrow word stream from the host bus and assembles 128-bit key and content groups. Holds the active key so that successive blocks reuse it. Presents each completed group, with its key and mode bit, through a valid/ready handshake that drives the encryptor's `content_i`, `key_i`, `encode_or_decode_i` and `v_i` inputs.

---
 rtl/sm4_word_packer.sv | 97 +++++++++
 tb/tb_sm4_word_packer.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/sm4_word_packer.sv
// sm4_word_packer: packs host words into 128-bit key/content groups and hands {content, key, mode} to the SM4 encryptor
//
// Ports:
//   clk_i, reset_i (async, active-low)
//   data_i / is_key_i / mode_i / v_i / ready_o : host word stream in; is_key_i selects the key or content path
//   content_o / key_o / encode_or_decode_o / v_o / ready_i : assembled group out with its bound key and mode
//   key_valid_o : an active key has been loaded
// Optional feature: define SM4_WORD_PACKER_SKID_EN to turn the output register into a 2-entry FIFO.
module sm4_word_packer #(
  parameter int group_size_p = 128,
  parameter int word_width_p = 32
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic [word_width_p-1:0] data_i,
  input  logic                    is_key_i,
  input  logic                    mode_i,
  input  logic                    v_i,
  output logic                    ready_o,
  output logic [group_size_p-1:0] content_o,
  output logic [group_size_p-1:0] key_o,
  output logic                    encode_or_decode_o,
  output logic                    v_o,
  input  logic                    ready_i,
  output logic                    key_valid_o
);
  localparam int words_p = group_size_p / word_width_p;
  localparam int cw_p = words_p > 1 ? $clog2(words_p) : 1;
  localparam logic [cw_p-1:0] last_p = cw_p'(words_p - 1);
  localparam logic [cw_p-1:0] one_p = cw_p'(1);
  localparam int ew_p = 2 * group_size_p + 1;
  typedef enum logic [1:0] {EMPTY, FULL, BOTH} state_e;
  state_e state_q, state_n;
  logic [cw_p-1:0] key_cnt, txt_cnt;
  logic [group_size_p-1:0] key_stage, txt_stage, key_act, key_next, txt_next;
  logic [ew_p-1:0] head_q, entry;
  logic key_acc, txt_acc, push, pop, can_take, last;
`ifdef SM4_WORD_PACKER_SKID_EN
  logic [ew_p-1:0] tail_q;
  assign can_take = state_q != BOTH || ready_i;
`else
  assign can_take = state_q == EMPTY || ready_i;
`endif
  // Shifting left keeps the first word of a group in the top bits.
  assign key_next = group_size_p'({key_stage, data_i});
  assign txt_next = group_size_p'({txt_stage, data_i});
  assign last = txt_cnt == last_p;
  assign ready_o = is_key_i || (key_valid_o && (!last || can_take));
  assign key_acc = v_i && is_key_i;
  assign txt_acc = v_i && !is_key_i && ready_o;
  assign push = txt_acc && last;
  assign pop = v_o && ready_i;
  assign v_o = state_q != EMPTY;
  assign entry = {txt_next, key_act, mode_i};
  assign {content_o, key_o, encode_or_decode_o} = head_q;
  // BOTH is only reachable with the skid FIFO; the single register blocks a push while held and not draining.
  always_comb begin
    state_n = state_q;
    state_n = state_q == EMPTY ? (push ? FULL : EMPTY)
            : state_q == FULL  ? (push && !pop ? BOTH : (!push && pop ? EMPTY : FULL))
            : (pop && !push ? FULL : BOTH);
  end
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q <= EMPTY;
      key_cnt <= '0;
      txt_cnt <= '0;
      key_stage <= '0;
      txt_stage <= '0;
      key_act <= '0;
      key_valid_o <= 1'b0;
      head_q <= '0;
`ifdef SM4_WORD_PACKER_SKID_EN
      tail_q <= '0;
`endif
    end else begin
      state_q <= state_n;
      if (key_acc) begin
        key_stage <= key_next;
        key_cnt <= key_cnt == last_p ? '0 : key_cnt + one_p;
        if (key_cnt == last_p) begin
          key_act <= key_next;
          key_valid_o <= 1'b1;
        end
      end
      if (txt_acc) begin
        txt_stage <= txt_next;
        txt_cnt <= last ? '0 : txt_cnt + one_p;
      end
      if (push && (state_q == EMPTY || (state_q == FULL && pop))) head_q <= entry;
`ifdef SM4_WORD_PACKER_SKID_EN
      else if (pop && state_q == BOTH) head_q <= tail_q;
      if (push && state_q != EMPTY && !(state_q == FULL && pop)) tail_q <= entry;
`endif
    end
  end
endmodule

// File: tb/tb_sm4_word_packer.sv
// tb_sm4_word_packer: scoreboard bench for sm4_word_packer
module tb_sm4_word_packer;
  logic clk_i = 1'b0, reset_i = 1'b0;
  logic [31:0] data_i = '0;
  logic is_key_i = 1'b0, mode_i = 1'b0, v_i = 1'b0, ready_i = 1'b0;
  logic ready_o, encode_or_decode_o, v_o, key_valid_o;
  logic [127:0] content_o, key_o;
  logic [256:0] q[$];
  int checks = 0, errors = 0, groups = 0, pushed = 0;

  localparam logic [127:0] K  = 128'h0123456789abcdeffedcba9876543210;
  localparam logic [127:0] K2 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] A  = 128'h10000001200000023000000340000004;
  localparam logic [127:0] B  = 128'hb0000001b0000002b0000003b0000004;
  localparam logic [127:0] C  = 128'hc0000001c0000002c0000003c0000004;
  localparam logic [127:0] D  = 128'ha0a0a0a0b1b1b1b1c2c2c2c2d3d3d3d3;
  localparam logic [127:0] X  = 128'h5555555566666666777777778888888a;
  localparam logic [127:0] Y  = 128'h99999999aaaaaaaabbbbbbbbcccccccc;
  localparam logic [127:0] R  = 128'hdead0000dead0001dead0002dead0003;
  localparam logic [127:0] E  = 128'he0e0e0e0e1e1e1e1e2e2e2e2e3e3e3e3;

  sm4_word_packer dut (
    .clk_i(clk_i), .reset_i(reset_i), .data_i(data_i), .is_key_i(is_key_i),
    .mode_i(mode_i), .v_i(v_i), .ready_o(ready_o), .content_o(content_o),
    .key_o(key_o), .encode_or_decode_o(encode_or_decode_o), .v_o(v_o),
    .ready_i(ready_i), .key_valid_o(key_valid_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [256:0] act, input logic [256:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic expect_grp(input logic [127:0] c, input logic [127:0] k, input logic m);
    q.push_back({c, k, m});
    pushed++;
  endtask

  task automatic put(input logic [31:0] d, input logic k, input logic m);
    int n = 0;
    data_i = d;
    is_key_i = k;
    mode_i = m;
    v_i = 1'b1;
    #1;
    while (!ready_o && n < 40) begin
      @(negedge clk_i);
      #1;
      n++;
    end
    if (!ready_o) begin
      checks++;
      errors++;
      $display("FAIL put_timeout actual=ready_o 0 required=ready_o 1 word=%h", d);
    end
    @(negedge clk_i);
    v_i = 1'b0;
  endtask

  task automatic key(input logic [127:0] k);
    for (int i = 0; i < 4; i++) put(k[127-32*i -: 32], 1'b1, 1'b0);
  endtask

  task automatic words(input logic [127:0] c, input logic m, input int lo, input int hi);
    for (int i = lo; i <= hi; i++) put(c[127-32*i -: 32], 1'b0, m);
  endtask

  task automatic grp(input logic [127:0] c, input logic [127:0] k, input logic m);
    expect_grp(c, k, m);
    words(c, m, 0, 3);
  endtask

  task automatic drain();
    int n = 0;
    ready_i = 1'b1;
    while ((q.size() != 0 || v_o) && n < 50) begin
      @(negedge clk_i);
      n++;
    end
    if (q.size() != 0 || v_o) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout actual=%0d pending required=0 pending", q.size());
    end
  endtask

  initial forever begin
    @(negedge clk_i);
    #2;
    if (v_o) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_group actual=%h required=none", content_o);
      end else begin
        chk(ready_i ? "group" : "hold", {content_o, key_o, encode_or_decode_o}, q[0]);
        if (ready_i) begin
          void'(q.pop_front());
          groups++;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge clk_i);
    chk("rst_v_o", v_o, 0);
    chk("rst_key_valid", key_valid_o, 0);
    chk("rst_content", content_o, 0);
    chk("rst_key", key_o, 0);
    chk("rst_mode", encode_or_decode_o, 0);
    reset_i = 1'b1;
    @(negedge clk_i);
    data_i = 32'h1;
    is_key_i = 1'b0;
    v_i = 1'b1;
    #1;
    chk("nokey_ready", ready_o, 0);
    chk("nokey_key_valid", key_valid_o, 0);
    chk("nokey_v_o", v_o, 0);
    is_key_i = 1'b1;
    #1;
    chk("key_ready", ready_o, 1);
    v_i = 1'b0;
    @(negedge clk_i);

    ready_i = 1'b1;
    key(K);
    chk("key_valid", key_valid_o, 1);
    expect_grp(K, K, 1'b0);
    words(K, 1'b0, 0, 3);
    chk("latency_v_o", v_o, 1);
    drain();

    ready_i = 1'b0;
    grp(A, K, 1'b0);
    chk("held_v_o", v_o, 1);
    expect_grp(B, K, 1'b0);
    words(B, 1'b0, 0, 2);
    data_i = B[31:0];
    is_key_i = 1'b0;
    mode_i = 1'b0;
    v_i = 1'b1;
    #1;
`ifdef SM4_WORD_PACKER_SKID_EN
    chk("stall_ready", ready_o, 1);
    @(negedge clk_i);
    v_i = 1'b0;
    expect_grp(C, K, 1'b1);
    words(C, 1'b1, 0, 2);
    data_i = C[31:0];
    mode_i = 1'b1;
    v_i = 1'b1;
    #1;
    chk("stall_full_ready", ready_o, 0);
    @(negedge clk_i);
    ready_i = 1'b1;
    put(C[31:0], 1'b0, 1'b1);
`else
    chk("stall_ready", ready_o, 0);
    @(negedge clk_i);
    ready_i = 1'b1;
    put(B[31:0], 1'b0, 1'b0);
`endif
    drain();

    expect_grp(D, K2, 1'b1);
    words(D, 1'b1, 0, 1);
    key(K2);
    words(D, 1'b1, 2, 3);
    drain();

    ready_i = 1'b0;
    grp(X, K2, 1'b0);
    expect_grp(Y, K2, 1'b0);
    words(Y, 1'b0, 0, 2);
    ready_i = 1'b1;
    put(Y[31:0], 1'b0, 1'b0);
    chk("simul_v_o", v_o, 1);
    chk("simul_content", content_o, Y);
    drain();

    words(R, 1'b0, 0, 1);
    reset_i = 1'b0;
    data_i = 32'h5;
    is_key_i = 1'b0;
    v_i = 1'b1;
    #1;
    chk("midrst_key_valid", key_valid_o, 0);
    chk("midrst_v_o", v_o, 0);
    chk("midrst_ready", ready_o, 0);
    chk("midrst_key", key_o, 0);
    v_i = 1'b0;
    @(negedge clk_i);
    reset_i = 1'b1;
    @(negedge clk_i);
    key(K);
    grp(E, K, 1'b0);
    drain();

    chk("group_count", groups, pushed);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
